// File: rtl/vote_entry_if.sv
// Keypad/button inputs and display/tally outputs of the voting terminal.
// The master side (keypad controller or bench) drives the inputs.
// The slave side (vote_entry) drives the display, status and tallies.
interface vote_entry_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       btn_confirma;
    logic       btn_corrige;
    logic       btn_branco;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic       busy;
    logic       vote_done;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;
    logic [7:0] cnt_nulo;
    logic [7:0] cnt_branco;

    modport master (
        output key_valid, key_code, btn_confirma, btn_corrige, btn_branco,
        input  dig1, dig2, busy, vote_done,
        input  cnt_a, cnt_b, cnt_c, cnt_nulo, cnt_branco
    );

    modport slave (
        input  key_valid, key_code, btn_confirma, btn_corrige, btn_branco,
        output dig1, dig2, busy, vote_done,
        output cnt_a, cnt_b, cnt_c, cnt_nulo, cnt_branco
    );
endinterface

// File: rtl/vote_entry.sv
// Two-digit vote entry terminal: collects a candidate number from the
// keypad, shows it on two 7-segment digits, and tallies the vote on confirm.
// A blank vote path bypasses the keypad. After each vote the terminal shows
// a blank display for HOLD_CYCLES cycles and ignores all inputs.
module vote_entry #(
    parameter logic [7:0] CAND_A      = 8'h13,
    parameter logic [7:0] CAND_B      = 8'h45,
    parameter logic [7:0] CAND_C      = 8'h72,
    parameter int         HOLD_CYCLES = 50
) (
    input  logic      clk,
    input  logic      rst,
    vote_entry_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIG1   = 3'd1,
        DIG2   = 3'd2,
        BRANCO = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] DISP_UNDER = 4'b1101;
    localparam logic [3:0] DISP_OFF   = 4'b1111;

    // Tally slot indices.
    localparam int IDX_A      = 0;
    localparam int IDX_B      = 1;
    localparam int IDX_C      = 2;
    localparam int IDX_NULO   = 3;
    localparam int IDX_BRANCO = 4;
    localparam int NUM_CNT    = 5;

    // Hold counter runs 0 .. HOLD_CYCLES-1 while in DONE.
    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          tens_q, tens_d;
    logic [3:0]          units_q, units_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          dig1_q, dig1_d;
    logic [3:0]          dig2_q, dig2_d;
    logic                busy_q, busy_d;
    logic                vote_done_q, vote_done_d;
    logic [NUM_CNT-1:0]  inc_d;
    logic [7:0]          cnt_q [NUM_CNT];

    logic                key_ok;
    logic [7:0]          entered;

    assign key_ok  = bus.key_valid && (bus.key_code <= 4'd9);
    assign entered = {tens_q, units_q};

    // State and entry registers; reset abandons any vote in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic. Within each state, corrige outranks confirma,
    // which outranks branco, which outranks a key; events a state does
    // not accept simply fall through to the next one.
    always_comb begin
        state_d     = state_q;
        tens_d      = tens_q;
        units_d     = units_q;
        hold_d      = hold_q;
        inc_d       = '0;
        vote_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.btn_branco) begin
                    state_d = BRANCO;
                end else if (key_ok) begin
                    tens_d  = bus.key_code;
                    state_d = DIG1;
                end
            end
            DIG1: begin
                if (bus.btn_corrige) begin
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                    state_d = IDLE;
                end else if (key_ok) begin
                    units_d = bus.key_code;
                    state_d = DIG2;
                end
            end
            DIG2: begin
                if (bus.btn_corrige) begin
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                    state_d = IDLE;
                end else if (bus.btn_confirma) begin
                    state_d     = DONE;
                    hold_d      = '0;
                    vote_done_d = 1'b1;
                    // Candidate A wins if parameters ever collide.
                    if (entered == CAND_A)      inc_d[IDX_A]    = 1'b1;
                    else if (entered == CAND_B) inc_d[IDX_B]    = 1'b1;
                    else if (entered == CAND_C) inc_d[IDX_C]    = 1'b1;
                    else                        inc_d[IDX_NULO] = 1'b1;
                end
            end
            BRANCO: begin
                if (bus.btn_corrige) begin
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                    state_d = IDLE;
                end else if (bus.btn_confirma) begin
                    state_d           = DONE;
                    hold_d            = '0;
                    vote_done_d       = 1'b1;
                    inc_d[IDX_BRANCO] = 1'b1;
                end
            end
            DONE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tens_d  = 4'd0;
                units_d = 4'd0;
                hold_d  = '0;
            end
        endcase
    end

    // Display and status decode from the upcoming state, so the registered
    // outputs line up with the state they describe.
    always_comb begin
        dig1_d = DISP_UNDER;
        dig2_d = DISP_UNDER;
        busy_d = 1'b0;
        case (state_d)
            IDLE: begin
                dig1_d = DISP_UNDER;
                dig2_d = DISP_UNDER;
            end
            DIG1: begin
                dig1_d = tens_d;
                dig2_d = DISP_UNDER;
            end
            DIG2: begin
                dig1_d = tens_d;
                dig2_d = units_d;
            end
            BRANCO: begin
                dig1_d = DISP_OFF;
                dig2_d = DISP_OFF;
            end
            DONE: begin
                dig1_d = DISP_OFF;
                dig2_d = DISP_OFF;
                busy_d = 1'b1;
            end
            default: begin
                dig1_d = DISP_UNDER;
                dig2_d = DISP_UNDER;
            end
        endcase
    end

    // Registered display/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dig1_q      <= DISP_UNDER;
            dig2_q      <= DISP_UNDER;
            busy_q      <= 1'b0;
            vote_done_q <= 1'b0;
        end else begin
            dig1_q      <= dig1_d;
            dig2_q      <= dig2_d;
            busy_q      <= busy_d;
            vote_done_q <= vote_done_d;
        end
    end

    // One saturating tally per outcome; a saturated tally still lets the
    // vote complete normally, it just stops counting.
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q[gi] <= 8'd0;
                end else if (inc_d[gi] && (cnt_q[gi] != 8'hFF)) begin
                    cnt_q[gi] <= cnt_q[gi] + 8'd1;
                end
            end
        end
    endgenerate

    assign bus.dig1       = dig1_q;
    assign bus.dig2       = dig2_q;
    assign bus.busy       = busy_q;
    assign bus.vote_done  = vote_done_q;
    assign bus.cnt_a      = cnt_q[IDX_A];
    assign bus.cnt_b      = cnt_q[IDX_B];
    assign bus.cnt_c      = cnt_q[IDX_C];
    assign bus.cnt_nulo   = cnt_q[IDX_NULO];
    assign bus.cnt_branco = cnt_q[IDX_BRANCO];

endmodule

// File: tb/tb_vote_entry.sv
// Bench for vote_entry: directed key/button sequences. Each confirm that
// should register a vote pushes the expected tallies into a queue; an
// independent monitor pops and compares whenever vote_done is seen.
module tb_vote_entry;

    localparam int         HOLD = 50;
    localparam logic [3:0] D_U  = 4'b1101;
    localparam logic [3:0] D_O  = 4'b1111;
    localparam int         A = 0, B = 1, C = 2, NUL = 3, BR = 4, NONE = -1;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   votes_seen;

    logic [7:0]  exp_cnt [5];
    logic [39:0] exp_q [$];

    vote_entry_if vif ();

    vote_entry #(
        .CAND_A      (8'h13),
        .CAND_B      (8'h45),
        .CAND_C      (8'h72),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // All stimulus tasks start and end at a falling edge.
    task automatic key(input logic [3:0] d);
        vif.key_valid = 1'b1;
        vif.key_code  = d;
        @(negedge clk);
        vif.key_valid = 1'b0;
    endtask

    task automatic corrige();
        vif.btn_corrige = 1'b1;
        @(negedge clk);
        vif.btn_corrige = 1'b0;
    endtask

    task automatic branco();
        vif.btn_branco = 1'b1;
        @(negedge clk);
        vif.btn_branco = 1'b0;
    endtask

    // cat selects the tally expected to move; NONE means no vote expected.
    task automatic confirm(input int cat);
        if (cat >= 0) begin
            if (exp_cnt[cat] != 8'hFF) exp_cnt[cat] = exp_cnt[cat] + 8'd1;
            exp_q.push_back({exp_cnt[BR], exp_cnt[NUL], exp_cnt[C], exp_cnt[B], exp_cnt[A]});
        end
        vif.btn_confirma = 1'b1;
        @(negedge clk);
        vif.btn_confirma = 1'b0;
    endtask

    task automatic chk_dig(input string name, input logic [3:0] d1, input logic [3:0] d2);
        chk({name, " dig1"}, {28'd0, vif.dig1}, {28'd0, d1});
        chk({name, " dig2"}, {28'd0, vif.dig2}, {28'd0, d2});
    endtask

    // Called right after a confirm: measures how long busy stays high.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (vif.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({name, " busy cycles"}, n, HOLD);
        chk_dig({name, " after done"}, D_U, D_U);
    endtask

    task automatic chk_counts(input string name);
        chk({name, " cnt_a"},      {24'd0, vif.cnt_a},      {24'd0, exp_cnt[A]});
        chk({name, " cnt_b"},      {24'd0, vif.cnt_b},      {24'd0, exp_cnt[B]});
        chk({name, " cnt_c"},      {24'd0, vif.cnt_c},      {24'd0, exp_cnt[C]});
        chk({name, " cnt_nulo"},   {24'd0, vif.cnt_nulo},   {24'd0, exp_cnt[NUL]});
        chk({name, " cnt_branco"}, {24'd0, vif.cnt_branco}, {24'd0, exp_cnt[BR]});
    endtask

    // Monitor: every vote_done pulse must match the oldest expected vote.
    always @(negedge clk) begin
        if (vif.vote_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected vote_done actual=1 required=0 at %0t", $time);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                votes_seen++;
                chk("vote cnt_a",      {24'd0, vif.cnt_a},      {24'd0, e[7:0]});
                chk("vote cnt_b",      {24'd0, vif.cnt_b},      {24'd0, e[15:8]});
                chk("vote cnt_c",      {24'd0, vif.cnt_c},      {24'd0, e[23:16]});
                chk("vote cnt_nulo",   {24'd0, vif.cnt_nulo},   {24'd0, e[31:24]});
                chk("vote cnt_branco", {24'd0, vif.cnt_branco}, {24'd0, e[39:32]});
                chk("vote busy",       {31'd0, vif.busy},       32'd1);
                $display("vote %0d: a=%0d b=%0d c=%0d nulo=%0d branco=%0d", votes_seen,
                         vif.cnt_a, vif.cnt_b, vif.cnt_c, vif.cnt_nulo, vif.cnt_branco);
            end
        end
    end

    initial begin
        int n;
        checks           = 0;
        failures         = 0;
        votes_seen       = 0;
        for (int i = 0; i < 5; i++) exp_cnt[i] = 8'd0;
        vif.key_valid    = 1'b0;
        vif.key_code     = 4'd0;
        vif.btn_confirma = 1'b0;
        vif.btn_corrige  = 1'b0;
        vif.btn_branco   = 1'b0;
        rst              = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state.
        chk_dig("reset", D_U, D_U);
        chk("reset busy", {31'd0, vif.busy}, 32'd0);
        chk("reset vote_done", {31'd0, vif.vote_done}, 32'd0);
        chk_counts("reset");

        // Vote for A: 1, 3, confirm.
        key(4'd1);
        chk_dig("A first key", 4'd1, D_U);
        key(4'd3);
        chk_dig("A second key", 4'd1, 4'd3);
        confirm(A);
        chk_dig("A in done", D_O, D_O);
        wait_done("A");

        // Null vote: 9, 9.
        key(4'd9);
        key(4'd9);
        confirm(NUL);
        wait_done("nulo");

        // Blank vote; keys ignored in BRANCO.
        branco();
        chk_dig("branco", D_O, D_O);
        key(4'd5);
        chk_dig("branco key ignored", D_O, D_O);
        confirm(BR);
        wait_done("branco");

        // Correction then vote for C; a third key is ignored.
        key(4'd4);
        corrige();
        chk_dig("after corrige", D_U, D_U);
        key(4'd7);
        key(4'd2);
        key(4'd5);
        chk_dig("third key ignored", 4'd7, 4'd2);
        confirm(C);
        wait_done("C");
        chk_counts("after C");

        // Confirm + corrige together in DIG2: corrige wins, no vote.
        key(4'd1);
        key(4'd3);
        vif.btn_confirma = 1'b1;
        vif.btn_corrige  = 1'b1;
        @(negedge clk);
        vif.btn_confirma = 1'b0;
        vif.btn_corrige  = 1'b0;
        chk_dig("confirm+corrige", D_U, D_U);
        chk("confirm+corrige busy", {31'd0, vif.busy}, 32'd0);
        repeat (2) @(negedge clk);
        chk_counts("confirm+corrige");

        // Events not accepted in IDLE, and an invalid key code.
        confirm(NONE);
        chk("idle confirm busy", {31'd0, vif.busy}, 32'd0);
        corrige();
        key(4'd12);
        chk_dig("idle ignored inputs", D_U, D_U);

        // Key held three cycles acts as three presses: 5, 5, then ignored.
        vif.key_valid = 1'b1;
        vif.key_code  = 4'd5;
        repeat (3) @(negedge clk);
        vif.key_valid = 1'b0;
        chk_dig("held key", 4'd5, 4'd5);
        // Branco in DIG2 is ignored.
        branco();
        chk_dig("branco in dig2", 4'd5, 4'd5);
        corrige();

        // Saturation: 256 more votes for A.
        for (int v = 0; v < 256; v++) begin
            key(4'd1);
            key(4'd3);
            confirm(A);
            wait_done("sat");
        end
        chk_counts("saturated");
        chk("cnt_a saturated", {24'd0, vif.cnt_a}, 32'd255);

        // Reset mid-DONE: vote registers, then is wiped by reset.
        key(4'd4);
        key(4'd5);
        confirm(B);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) exp_cnt[i] = 8'd0;
        chk_dig("rst mid-done", D_U, D_U);
        chk("rst mid-done busy", {31'd0, vif.busy}, 32'd0);
        chk_counts("rst mid-done");

        // Reset mid-entry.
        key(4'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_dig("rst mid-entry", D_U, D_U);
        key(4'd8);
        chk_dig("entry after rst", 4'd8, D_U);

        // Every expected vote must have been observed.
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("pending votes", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
